// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and its commit path into the register file.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int REG_WIDTH_DEF = 5;
    localparam int DATA_WIDTH    = 32;

    // One in-flight instruction slot.
    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic                     mispredict;
        logic                     hasDest;
        logic [REG_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH-1:0]    value;
        logic [DATA_WIDTH-1:0]    target;
    } rob_entry_t;

    // Register-file commit write, as seen by the register file interface.
    typedef struct packed {
        logic                     flag;
        logic [ROB_WIDTH_DEF-1:0] src;
        logic [REG_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } commit_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, collects writeback results,
// retires in program order into the register file and raises a one-cycle
// pipeline clear when a mispredicted branch commits.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  rdyIn,

    input  logic                  issueFlag,
    input  logic [REG_WIDTH-1:0]  issueReg,
    input  logic                  issueHasDest,
    output logic                  issueReady,
    output logic [ROB_WIDTH-1:0]  issueTag,

    input  logic                  wbFlag,
    input  logic [ROB_WIDTH-1:0]  wbTag,
    input  logic [DATA_WIDTH-1:0] wbData,
    input  logic                  wbMispredict,
    input  logic [DATA_WIDTH-1:0] wbTarget,

    input  logic [ROB_WIDTH-1:0]  rs1Tag,
    input  logic [ROB_WIDTH-1:0]  rs2Tag,
    output logic                  rs1Ready,
    output logic                  rs2Ready,
    output logic [DATA_WIDTH-1:0] rs1Value,
    output logic [DATA_WIDTH-1:0] rs2Value,

    output logic                  writeFlag,
    output logic [ROB_WIDTH-1:0]  writeSrc,
    output logic [REG_WIDTH-1:0]  writeReg,
    output logic [DATA_WIDTH-1:0] writeData,

    output logic                  clrOut,
    output logic [DATA_WIDTH-1:0] redirectPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    rob_entry_t           entries [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    commit_t              commitQ;
    logic                 clrQ;

    rob_entry_t headEntry;
    logic       full;
    logic       doIssue;
    logic       doWb;
    logic       doCommit;
    logic       rs1Hit;
    logic       rs2Hit;

    // Per-cycle decisions, all taken from registered state.
    always_comb begin
        // NOTE: every always_comb output gets a value before any condition so no latch is inferred.
        headEntry  = entries[head];
        full       = (count == (ROB_WIDTH+1)'(DEPTH));
        issueReady = !full && rdyIn && !clrQ;
        doIssue    = issueFlag && issueReady;
        doWb       = rdyIn && !clrQ && wbFlag && entries[wbTag].busy;
        doCommit   = rdyIn && !clrQ && headEntry.busy && headEntry.done;
    end

    // Pointer, entry array, commit and flush state.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            commitQ    <= '0;
            clrQ       <= 1'b0;
            redirectPc <= '0;
            // NOTE: the entry array is a small flop array, so it is reset with everything else; a RAM-backed array would not be.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (rdyIn) begin
            if (clrQ) begin
                // The clear cycle has been seen by every unit: drop all in-flight work.
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].busy <= 1'b0;
                    entries[i].done <= 1'b0;
                end
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                clrQ         <= 1'b0;
                commitQ.flag <= 1'b0;
            end else begin
                commitQ.flag <= 1'b0;

                if (doWb) begin
                    entries[wbTag].done       <= 1'b1;
                    entries[wbTag].value      <= wbData;
                    entries[wbTag].mispredict <= wbMispredict;
                    entries[wbTag].target     <= wbTarget;
                end

                if (doIssue) begin
                    entries[tail] <= '{busy: 1'b1, done: 1'b0, mispredict: 1'b0,
                                       hasDest: issueHasDest, rd: issueReg,
                                       value: '0, target: '0};
                    tail <= tail + 1'b1;
                end

                // Commit is placed after writeback so freeing the head wins over a late write to it.
                if (doCommit) begin
                    entries[head].busy <= 1'b0;
                    entries[head].done <= 1'b0;
                    head               <= head + 1'b1;
                    commitQ            <= '{flag: headEntry.hasDest && (headEntry.rd != '0),
                                            src: head, rd: headEntry.rd, data: headEntry.value};
                    if (headEntry.mispredict) begin
                        clrQ       <= 1'b1;
                        redirectPc <= headEntry.target;
                    end
                end

                count <= count + {{ROB_WIDTH{1'b0}}, doIssue} - {{ROB_WIDTH{1'b0}}, doCommit};
            end
        end
    end

    // Strobes are held through a stall but only presented while the pipeline is enabled.
    assign writeFlag = commitQ.flag && rdyIn;
    assign writeSrc  = commitQ.src;
    assign writeReg  = commitQ.rd;
    assign writeData = commitQ.data;
    assign clrOut    = clrQ && rdyIn;
    assign issueTag  = tail;

    // Operand bypass: a same-cycle writeback to a live entry beats the stored value.
    assign rs1Hit   = wbFlag && (wbTag == rs1Tag) && entries[rs1Tag].busy;
    assign rs2Hit   = wbFlag && (wbTag == rs2Tag) && entries[rs2Tag].busy;
    assign rs1Ready = entries[rs1Tag].done || rs1Hit;
    assign rs2Ready = entries[rs2Tag].done || rs2Hit;
    assign rs1Value = rs1Hit ? wbData : (entries[rs1Tag].busy ? entries[rs1Tag].value : '0);
    assign rs2Value = rs2Hit ? wbData : (entries[rs2Tag].busy ? entries[rs2Tag].value : '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// run against a program-order queue model.
module tb_reorder_buffer;

    localparam int RW    = 4;
    localparam int GW    = 5;
    localparam int DEPTH = 16;

    logic          clkIn = 1'b0;
    logic          rstIn;
    logic          rdyIn;
    logic          issueFlag;
    logic [GW-1:0] issueReg;
    logic          issueHasDest;
    logic          issueReady;
    logic [RW-1:0] issueTag;
    logic          wbFlag;
    logic [RW-1:0] wbTag;
    logic [31:0]   wbData;
    logic          wbMispredict;
    logic [31:0]   wbTarget;
    logic [RW-1:0] rs1Tag;
    logic [RW-1:0] rs2Tag;
    logic          rs1Ready;
    logic          rs2Ready;
    logic [31:0]   rs1Value;
    logic [31:0]   rs2Value;
    logic          writeFlag;
    logic [RW-1:0] writeSrc;
    logic [GW-1:0] writeReg;
    logic [31:0]   writeData;
    logic          clrOut;
    logic [31:0]   redirectPc;

    int checks = 0;
    int passes = 0;

    reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .rdyIn(rdyIn),
        .issueFlag(issueFlag), .issueReg(issueReg), .issueHasDest(issueHasDest),
        .issueReady(issueReady), .issueTag(issueTag),
        .wbFlag(wbFlag), .wbTag(wbTag), .wbData(wbData),
        .wbMispredict(wbMispredict), .wbTarget(wbTarget),
        .rs1Tag(rs1Tag), .rs2Tag(rs2Tag), .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
        .rs1Value(rs1Value), .rs2Value(rs2Value),
        .writeFlag(writeFlag), .writeSrc(writeSrc), .writeReg(writeReg), .writeData(writeData),
        .clrOut(clrOut), .redirectPc(redirectPc)
    );

    always #5 clkIn = ~clkIn;

    // ---------------- reference model: instructions in program order ----------------
    typedef struct {
        logic [RW-1:0] tag;
        logic [GW-1:0] rd;
        logic          hasDest;
        logic          done;
        logic [31:0]   value;
        logic          mis;
        logic [31:0]   target;
    } instr_t;

    instr_t        q[$];
    int            nextTag;
    bit            mClr;
    logic [31:0]   mRedirect;
    bit            mWf;
    logic [RW-1:0] mWs;
    logic [GW-1:0] mWr;
    logic [31:0]   mWd;

    function automatic int find_tag(logic [RW-1:0] t);
        foreach (q[i]) if (q[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        nextTag   = 0;
        mClr      = 0;
        mRedirect = '0;
        mWf       = 0;
        mWs       = '0;
        mWr       = '0;
        mWd       = '0;
    endtask

    // Applies one clock edge worth of effect using the inputs currently driven.
    task automatic model_edge();
        bit     doIssue;
        int     idx;
        instr_t c;
        instr_t n;
        if (!rdyIn) return;
        if (mClr) begin
            q.delete();
            nextTag = 0;
            mClr    = 0;
            mWf     = 0;
            return;
        end
        doIssue = issueFlag && (q.size() < DEPTH);
        mWf = 0;
        if (q.size() > 0 && q[0].done) begin
            c   = q.pop_front();
            mWf = c.hasDest && (c.rd != 0);
            mWs = c.tag;
            mWr = c.rd;
            mWd = c.value;
            if (c.mis) begin
                mClr      = 1;
                mRedirect = c.target;
            end
        end
        if (wbFlag) begin
            idx = find_tag(wbTag);
            if (idx >= 0) begin
                q[idx].done   = 1'b1;
                q[idx].value  = wbData;
                q[idx].mis    = wbMispredict;
                q[idx].target = wbTarget;
            end
        end
        if (doIssue) begin
            n.tag     = RW'(nextTag);
            n.rd      = issueReg;
            n.hasDest = issueHasDest;
            n.done    = 1'b0;
            n.value   = '0;
            n.mis     = 1'b0;
            n.target  = '0;
            q.push_back(n);
            nextTag = (nextTag + 1) % DEPTH;
        end
    endtask

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic idle();
        rdyIn        = 1'b1;
        issueFlag    = 1'b0;
        issueReg     = '0;
        issueHasDest = 1'b0;
        wbFlag       = 1'b0;
        wbTag        = '0;
        wbData       = '0;
        wbMispredict = 1'b0;
        wbTarget     = '0;
        rs1Tag       = '0;
        rs2Tag       = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clkIn);
        @(negedge clkIn);
    endtask

    task automatic apply_reset();
        idle();
        rstIn = 1'b0;
        model_reset();
        @(negedge clkIn);
        @(negedge clkIn);
        rstIn = 1'b1;
    endtask

    task automatic issue_one(input logic [GW-1:0] rd, input logic hasDest);
        issueFlag    = 1'b1;
        issueReg     = rd;
        issueHasDest = hasDest;
        tick();
        issueFlag    = 1'b0;
    endtask

    task automatic wb_one(input logic [RW-1:0] tag, input logic [31:0] data,
                          input logic mis, input logic [31:0] tgt);
        wbFlag       = 1'b1;
        wbTag        = tag;
        wbData       = data;
        wbMispredict = mis;
        wbTarget     = tgt;
        tick();
        wbFlag       = 1'b0;
        wbMispredict = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rstIn = 1'b0;
        model_reset();
        #1;
        checks++; if (writeFlag !== 1'b0) $display("FAIL reset_wflag: got %0b want 0", writeFlag); else passes++;
        checks++; if (clrOut !== 1'b0) $display("FAIL reset_clr: got %0b want 0", clrOut); else passes++;
        checks++; if (redirectPc !== 32'h0) $display("FAIL reset_redirect: got %h want 0", redirectPc); else passes++;
        checks++; if (writeData !== 32'h0) $display("FAIL reset_wdata: got %h want 0", writeData); else passes++;
        checks++; if (issueTag !== 4'd0) $display("FAIL reset_tag: got %0d want 0", issueTag); else passes++;
        @(negedge clkIn);
        rstIn = 1'b1;
        #1;
        checks++; if (issueReady !== 1'b1) $display("FAIL reset_ready: got %0b want 1", issueReady); else passes++;
        // Stall: issue must be refused and nothing allocated.
        rdyIn     = 1'b0;
        issueFlag = 1'b1;
        #1;
        checks++; if (issueReady !== 1'b0) $display("FAIL stall_ready: got %0b want 0", issueReady); else passes++;
        tick();
        idle();
        #1;
        checks++; if (issueTag !== 4'd0) $display("FAIL stall_no_alloc: tag got %0d want 0", issueTag); else passes++;
    endtask

    task automatic test_basic_commit();
        apply_reset();
        issueFlag = 1'b1; issueReg = 5'd5; issueHasDest = 1'b1;
        #1;
        checks++; if (issueTag !== 4'd0) $display("FAIL basic_tag: got %0d want 0", issueTag); else passes++;
        tick();
        idle();
        wb_one(4'd0, 32'h1234, 1'b0, 32'h0);
        #1;
        checks++; if (writeFlag !== 1'b0) $display("FAIL basic_early: wflag got %0b want 0", writeFlag); else passes++;
        tick();
        #1;
        checks++; if (writeFlag !== 1'b1) $display("FAIL basic_wflag: got %0b want 1", writeFlag); else passes++;
        checks++; if (writeSrc !== 4'd0) $display("FAIL basic_wsrc: got %0d want 0", writeSrc); else passes++;
        checks++; if (writeReg !== 5'd5) $display("FAIL basic_wreg: got %0d want 5", writeReg); else passes++;
        checks++; if (writeData !== 32'h1234) $display("FAIL basic_wdata: got %h want 1234", writeData); else passes++;
        checks++; if (dut.count !== 5'd0) $display("FAIL basic_count: got %0d want 0", dut.count); else passes++;
        tick();
        #1;
        checks++; if (writeFlag !== 1'b0) $display("FAIL basic_pulse: wflag got %0b want 0", writeFlag); else passes++;
    endtask

    task automatic test_full();
        int badTag;
        apply_reset();
        badTag = 0;
        for (int i = 0; i < DEPTH; i++) begin
            issueFlag = 1'b1; issueReg = GW'(i + 1); issueHasDest = 1'b1;
            #1;
            if (issueTag !== RW'(i)) badTag++;
            tick();
        end
        checks++; if (badTag != 0) $display("FAIL full_tags: %0d wrong tags want 0", badTag); else passes++;
        #1;
        checks++; if (issueReady !== 1'b0) $display("FAIL full_ready: got %0b want 0", issueReady); else passes++;
        checks++; if (issueTag !== 4'd0) $display("FAIL full_wrap: tag got %0d want 0", issueTag); else passes++;
        tick();  // 17th issueFlag still asserted
        checks++; if (dut.count !== 5'd16) $display("FAIL full_ignore: count got %0d want 16", dut.count); else passes++;
        idle();
        wb_one(4'd0, 32'h55, 1'b0, 32'h0);
        // Commit edge with an issue attempt: the freed slot is not usable this cycle.
        issueFlag = 1'b1; issueReg = 5'd9; issueHasDest = 1'b1;
        #1;
        checks++; if (issueReady !== 1'b0) $display("FAIL full_same_cycle: ready got %0b want 0", issueReady); else passes++;
        tick();
        idle();
        #1;
        checks++; if (writeFlag !== 1'b1 || writeSrc !== 4'd0) $display("FAIL full_commit: flag %0b src %0d want 1/0", writeFlag, writeSrc); else passes++;
        checks++; if (dut.count !== 5'd15) $display("FAIL full_count: got %0d want 15", dut.count); else passes++;
        checks++; if (issueReady !== 1'b1 || issueTag !== 4'd0) $display("FAIL full_reopen: ready %0b tag %0d want 1/0", issueReady, issueTag); else passes++;
    endtask

    task automatic test_out_of_order();
        apply_reset();
        for (int i = 0; i < 3; i++) issue_one(GW'(i + 1), 1'b1);
        wb_one(4'd2, 32'h22, 1'b0, 32'h0);
        wb_one(4'd1, 32'h11, 1'b0, 32'h0);
        #1;
        checks++; if (writeFlag !== 1'b0) $display("FAIL ooo_hold: wflag got %0b want 0", writeFlag); else passes++;
        wb_one(4'd0, 32'h10, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] expData;
            expData = (k == 0) ? 32'h10 : ((k == 1) ? 32'h11 : 32'h22);
            tick();
            #1;
            checks++;
            if (writeFlag !== 1'b1 || writeSrc !== RW'(k) || writeData !== expData)
                $display("FAIL ooo_commit%0d: flag %0b src %0d data %h want 1/%0d/%h", k, writeFlag, writeSrc, writeData, k, expData);
            else passes++;
        end
    endtask

    task automatic test_mispredict();
        int stray;
        apply_reset();
        for (int i = 0; i < 4; i++) issue_one(GW'(i + 1), 1'b1);
        wb_one(4'd0, 32'h100, 1'b0, 32'h0);
        wb_one(4'd1, 32'h200, 1'b1, 32'h80);
        #1;
        checks++; if (writeFlag !== 1'b1 || writeSrc !== 4'd0) $display("FAIL mis_first: flag %0b src %0d want 1/0", writeFlag, writeSrc); else passes++;
        tick();
        // Clear cycle: drive a writeback and an issue that must both be ignored.
        wbFlag = 1'b1; wbTag = 4'd2; wbData = 32'h333;
        issueFlag = 1'b1; issueReg = 5'd3; issueHasDest = 1'b1;
        #1;
        checks++; if (writeFlag !== 1'b1 || writeSrc !== 4'd1 || writeData !== 32'h200) $display("FAIL mis_commit: flag %0b src %0d data %h want 1/1/200", writeFlag, writeSrc, writeData); else passes++;
        checks++; if (clrOut !== 1'b1 || redirectPc !== 32'h80) $display("FAIL mis_clr: clr %0b pc %h want 1/80", clrOut, redirectPc); else passes++;
        checks++; if (issueReady !== 1'b0) $display("FAIL mis_block: ready got %0b want 0", issueReady); else passes++;
        tick();
        idle();
        #1;
        checks++; if (clrOut !== 1'b0) $display("FAIL mis_pulse: clr got %0b want 0", clrOut); else passes++;
        checks++; if (dut.count !== 5'd0 || issueTag !== 4'd0 || issueReady !== 1'b1) $display("FAIL mis_flush: count %0d tag %0d ready %0b want 0/0/1", dut.count, issueTag, issueReady); else passes++;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            if (writeFlag !== 1'b0) stray++;
            tick();
            #1;
        end
        checks++; if (stray != 0) $display("FAIL mis_no_commit: %0d stray writes want 0", stray); else passes++;
    endtask

    task automatic test_bypass();
        apply_reset();
        issue_one(5'd0, 1'b1);
        for (int i = 1; i < 4; i++) issue_one(5'd7, 1'b1);
        rs1Tag = 4'd3; rs2Tag = 4'd5;
        #1;
        checks++; if (rs1Ready !== 1'b0) $display("FAIL byp_pending: ready got %0b want 0", rs1Ready); else passes++;
        wbFlag = 1'b1; wbTag = 4'd3; wbData = 32'hABCD;
        #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'hABCD) $display("FAIL byp_forward: ready %0b val %h want 1/abcd", rs1Ready, rs1Value); else passes++;
        checks++; if (rs2Ready !== 1'b0 || rs2Value !== 32'h0) $display("FAIL byp_free: ready %0b val %h want 0/0", rs2Ready, rs2Value); else passes++;
        tick();
        wbFlag = 1'b0;
        #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'hABCD) $display("FAIL byp_stored: ready %0b val %h want 1/abcd", rs1Ready, rs1Value); else passes++;
        wb_one(4'd0, 32'h77, 1'b0, 32'h0);
        tick();
        #1;
        checks++; if (writeFlag !== 1'b0) $display("FAIL byp_rd0: wflag got %0b want 0", writeFlag); else passes++;
        checks++; if (dut.count !== 5'd3) $display("FAIL byp_rd0_count: got %0d want 3", dut.count); else passes++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 6; i++) issue_one(GW'(i + 10), 1'b1);
        wb_one(4'd0, 32'hDEAD, 1'b1, 32'hC0);
        tick();
        #1;
        checks++; if (clrOut !== 1'b1 || writeFlag !== 1'b1) $display("FAIL rmid_setup: clr %0b wflag %0b want 1/1", clrOut, writeFlag); else passes++;
        #1;
        rstIn = 1'b0;
        model_reset();
        #1;
        checks++; if (writeFlag !== 1'b0 || clrOut !== 1'b0) $display("FAIL rmid_strobes: wflag %0b clr %0b want 0/0", writeFlag, clrOut); else passes++;
        checks++; if (redirectPc !== 32'h0 || writeData !== 32'h0 || writeSrc !== 4'd0) $display("FAIL rmid_values: pc %h data %h src %0d want 0", redirectPc, writeData, writeSrc); else passes++;
        @(negedge clkIn);
        rstIn = 1'b1;
        #1;
        checks++; if (issueTag !== 4'd0 || issueReady !== 1'b1) $display("FAIL rmid_release: tag %0d ready %0b want 0/1", issueTag, issueReady); else passes++;
    endtask

    task automatic test_random();
        logic [RW-1:0] qtag [2];
        logic          obsRdy [2];
        logic [31:0]   obsVal [2];
        int            idx;
        bit            expRdy;
        bit            match;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rdyIn        = ($urandom_range(0, 9) != 0);
            issueFlag    = ($urandom_range(0, 9) < 6);
            issueReg     = GW'($urandom);
            issueHasDest = ($urandom_range(0, 3) != 0);
            wbFlag       = $urandom_range(0, 1);
            if (q.size() > 0 && $urandom_range(0, 4) != 0) wbTag = q[$urandom_range(0, q.size() - 1)].tag;
            else wbTag = RW'($urandom);
            wbData       = $urandom;
            wbMispredict = ($urandom_range(0, 39) == 0);
            wbTarget     = $urandom;
            rs1Tag       = $urandom_range(0, 1) ? wbTag : RW'($urandom);
            rs2Tag       = RW'($urandom);
            #1;
            checks++;
            if (issueReady !== (rdyIn && (q.size() < DEPTH) && !mClr))
                $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, issueReady, rdyIn && (q.size() < DEPTH) && !mClr);
            else passes++;
            checks++; if (issueTag !== RW'(nextTag)) $display("FAIL rnd_tag c%0d: got %0d want %0d", cyc, issueTag, nextTag); else passes++;
            checks++;
            if (writeFlag !== (mWf && rdyIn)) $display("FAIL rnd_wflag c%0d: got %0b want %0b", cyc, writeFlag, mWf && rdyIn);
            else passes++;
            if (mWf && rdyIn) begin
                checks++;
                if (writeSrc !== mWs || writeReg !== mWr || writeData !== mWd)
                    $display("FAIL rnd_write c%0d: src %0d reg %0d data %h want %0d/%0d/%h", cyc, writeSrc, writeReg, writeData, mWs, mWr, mWd);
                else passes++;
            end
            checks++; if (clrOut !== (mClr && rdyIn)) $display("FAIL rnd_clr c%0d: got %0b want %0b", cyc, clrOut, mClr && rdyIn); else passes++;
            if (mClr && rdyIn) begin
                checks++; if (redirectPc !== mRedirect) $display("FAIL rnd_pc c%0d: got %h want %h", cyc, redirectPc, mRedirect); else passes++;
            end
            qtag[0] = rs1Tag;   qtag[1] = rs2Tag;
            obsRdy[0] = rs1Ready; obsRdy[1] = rs2Ready;
            obsVal[0] = rs1Value; obsVal[1] = rs2Value;
            for (int p = 0; p < 2; p++) begin
                idx = find_tag(qtag[p]);
                if (idx < 0) begin
                    checks++;
                    if (obsRdy[p] !== 1'b0 || obsVal[p] !== 32'h0)
                        $display("FAIL rnd_rs%0d_free c%0d: ready %0b val %h want 0/0", p + 1, cyc, obsRdy[p], obsVal[p]);
                    else passes++;
                end else begin
                    match  = wbFlag && (wbTag == qtag[p]);
                    expRdy = q[idx].done || match;
                    checks++;
                    if (obsRdy[p] !== expRdy) $display("FAIL rnd_rs%0d_ready c%0d: got %0b want %0b", p + 1, cyc, obsRdy[p], expRdy);
                    else passes++;
                    if (match || q[idx].done) begin
                        checks++;
                        if (obsVal[p] !== (match ? wbData : q[idx].value))
                            $display("FAIL rnd_rs%0d_value c%0d: got %h want %h", p + 1, cyc, obsVal[p], match ? wbData : q[idx].value);
                        else passes++;
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rstIn = 1'b0;
        model_reset();
        @(negedge clkIn);
        test_reset();
        test_basic_commit();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
